// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants, instruction field positions, FSM encoding and
// the decoded-control bundle used by the instruction sequencer.
package instr_sequencer_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_ADDC  = 4'h2;
  localparam logic [3:0] OP_SUB   = 4'h3;
  localparam logic [3:0] OP_SUBB  = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_NOT   = 4'h8;
  localparam logic [3:0] OP_MOVIL = 4'h9;
  localparam logic [3:0] OP_MOVIH = 4'hA;
  localparam logic [3:0] OP_LOAD  = 4'hB;
  localparam logic [3:0] OP_STORE = 4'hC;
  localparam logic [3:0] OP_RSV0  = 4'hD;
  localparam logic [3:0] OP_RSV1  = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef struct packed {
    logic wr;
    logic movil;
    logic movih;
    logic flag_hold;
    logic is_mem;
    logic is_store;
    logic is_halt;
  } dec_t;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational opcode -> control mapping used for sequencing and commit strobes.
module instr_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '0;
    // Every op from ADD through MOVIH writes rd; LOAD writes in WB instead.
    dec_o.wr        = (op_i >= OP_ADD) && (op_i <= OP_MOVIH);
    dec_o.movil     = (op_i == OP_MOVIL);
    dec_o.movih     = (op_i == OP_MOVIH);
    dec_o.flag_hold = (op_i == OP_NOP) || ((op_i >= OP_AND) && (op_i <= OP_MOVIH)) ||
                      (op_i == OP_RSV0) || (op_i == OP_RSV1);
    dec_o.is_mem    = (op_i == OP_LOAD) || (op_i == OP_STORE);
    dec_o.is_store  = (op_i == OP_STORE);
    dec_o.is_halt   = (op_i == OP_HALT);
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/commit controller feeding the 8x16 register file; sequences
// ALU ops in 3 cycles and LOAD/STORE through the data port in 4 (zero-wait acks).
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk_pi,
  input  logic            reset_pi,
  output logic            imem_req_po,
  output logic [PC_W-1:0] imem_addr_po,
  input  logic            imem_ack_pi,
  input  logic [15:0]     imem_data_pi,
  output logic [2:0]      source_reg1_po,
  output logic [2:0]      source_reg2_po,
  output logic [2:0]      destination_reg_po,
  output logic            wr_destination_reg_po,
  output logic            movi_lower_po,
  output logic            movi_higher_po,
  output logic [7:0]      immediate_po,
  output logic            clk_en_po,
  output logic [3:0]      alu_op_po,
  output logic            flag_hold_po,
  output logic            load_sel_po,
  output logic [15:0]     load_data_po,
  input  logic [15:0]     reg1_data_pi,
  input  logic [15:0]     regD_data_pi,
  output logic            dmem_req_po,
  output logic            dmem_we_po,
  output logic [15:0]     dmem_addr_po,
  output logic [15:0]     dmem_wdata_po,
  input  logic            dmem_ack_pi,
  input  logic [15:0]     dmem_rdata_pi,
  output logic            halted_po
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [2:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [7:0]      imm_q, imm_d;
  logic [3:0]      op_q, op_d;
  logic [15:0]     load_data_q, load_data_d;
  logic            fetch_req;
  dec_t            dec;

  // IR is only rewritten in FETCH, so decoding it directly stays valid through commit.
  instr_decode u_dec (
    .op_i  (ir_q[OP_MSB:OP_LSB]),
    .dec_o (dec)
  );

  always_ff @(posedge clk_pi or posedge reset_pi) begin
    if (reset_pi) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      op_q        <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      imm_q       <= imm_d;
      op_q        <= op_d;
      load_data_q <= load_data_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    pc_d                  = pc_q;
    ir_d                  = ir_q;
    rs1_d                 = rs1_q;
    rs2_d                 = rs2_q;
    rd_d                  = rd_q;
    imm_d                 = imm_q;
    op_d                  = op_q;
    load_data_d           = load_data_q;
    fetch_req             = 1'b0;
    wr_destination_reg_po = 1'b0;
    movi_lower_po         = 1'b0;
    movi_higher_po        = 1'b0;
    clk_en_po             = 1'b0;
    flag_hold_po          = 1'b0;
    load_sel_po           = 1'b0;
    dmem_req_po           = 1'b0;
    dmem_we_po            = 1'b0;
    dmem_addr_po          = '0;
    dmem_wdata_po         = '0;
    halted_po             = 1'b0;
    case (state_q)
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (imem_ack_pi) begin
          ir_d    = imem_data_pi;
          pc_d    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        op_d  = ir_q[OP_MSB:OP_LSB];
        rd_d  = ir_q[RD_MSB:RD_LSB];
        rs1_d = ir_q[RS1_MSB:RS1_LSB];
        rs2_d = ir_q[RS2_MSB:RS2_LSB];
        imm_d = ir_q[IMM_MSB:IMM_LSB];
        if (dec.is_halt)     state_d = ST_HALT;
        else if (dec.is_mem) state_d = ST_MEM;
        else                 state_d = ST_EXEC;
      end
      ST_EXEC: begin
        clk_en_po             = 1'b1;
        wr_destination_reg_po = dec.wr;
        movi_lower_po         = dec.movil;
        movi_higher_po        = dec.movih;
        flag_hold_po          = dec.flag_hold;
        state_d               = ST_FETCH;
      end
      ST_MEM: begin
        dmem_req_po   = 1'b1;
        dmem_we_po    = dec.is_store;
        dmem_addr_po  = reg1_data_pi;
        dmem_wdata_po = regD_data_pi;
        if (dmem_ack_pi) begin
          if (!dec.is_store) load_data_d = dmem_rdata_pi;
          state_d = ST_WB;
        end
      end
      ST_WB: begin
        clk_en_po             = 1'b1;
        flag_hold_po          = 1'b1;
        wr_destination_reg_po = !dec.is_store;
        load_sel_po           = !dec.is_store;
        state_d               = ST_FETCH;
      end
      ST_HALT: halted_po = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset forces state to FETCH, so the request is masked to stay low while held.
  assign imem_req_po        = fetch_req & ~reset_pi;
  assign imem_addr_po       = pc_q;
  assign source_reg1_po     = rs1_q;
  assign source_reg2_po     = rs2_q;
  assign destination_reg_po = rd_q;
  assign immediate_po       = imm_q;
  assign alu_op_po          = op_q;
  assign load_data_po       = load_data_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: ALU, MOVIL, LOAD/STORE, resets, PC wrap, HALT.
module tb_instr_sequencer;

  logic        clk_pi = 1'b0;
  logic        reset_pi = 1'b1;
  logic        imem_req_po;
  logic [7:0]  imem_addr_po;
  logic        imem_ack_pi = 1'b0;
  logic [15:0] imem_data_pi = '0;
  logic [2:0]  source_reg1_po, source_reg2_po, destination_reg_po;
  logic        wr_destination_reg_po, movi_lower_po, movi_higher_po;
  logic [7:0]  immediate_po;
  logic        clk_en_po;
  logic [3:0]  alu_op_po;
  logic        flag_hold_po, load_sel_po;
  logic [15:0] load_data_po;
  logic [15:0] reg1_data_pi = '0;
  logic [15:0] regD_data_pi = '0;
  logic        dmem_req_po, dmem_we_po;
  logic [15:0] dmem_addr_po, dmem_wdata_po;
  logic        dmem_ack_pi = 1'b0;
  logic [15:0] dmem_rdata_pi = '0;
  logic        halted_po;

  int checks = 0;
  int failures = 0;

  instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk_pi(clk_pi), .reset_pi(reset_pi),
    .imem_req_po(imem_req_po), .imem_addr_po(imem_addr_po),
    .imem_ack_pi(imem_ack_pi), .imem_data_pi(imem_data_pi),
    .source_reg1_po(source_reg1_po), .source_reg2_po(source_reg2_po),
    .destination_reg_po(destination_reg_po),
    .wr_destination_reg_po(wr_destination_reg_po),
    .movi_lower_po(movi_lower_po), .movi_higher_po(movi_higher_po),
    .immediate_po(immediate_po), .clk_en_po(clk_en_po), .alu_op_po(alu_op_po),
    .flag_hold_po(flag_hold_po), .load_sel_po(load_sel_po), .load_data_po(load_data_po),
    .reg1_data_pi(reg1_data_pi), .regD_data_pi(regD_data_pi),
    .dmem_req_po(dmem_req_po), .dmem_we_po(dmem_we_po),
    .dmem_addr_po(dmem_addr_po), .dmem_wdata_po(dmem_wdata_po),
    .dmem_ack_pi(dmem_ack_pi), .dmem_rdata_pi(dmem_rdata_pi),
    .halted_po(halted_po)
  );

  always #5 clk_pi = ~clk_pi;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge in FETCH; returns at the DECODE-cycle negedge.
  task automatic fetch(input logic [15:0] instr);
    chk("fetch_req", imem_req_po, 1);
    imem_ack_pi  = 1'b1;
    imem_data_pi = instr;
    @(negedge clk_pi);
    imem_ack_pi  = 1'b0;
  endtask

  initial begin
    int n;
    #12;
    chk("rst_imem_req", imem_req_po, 0);
    chk("rst_imem_addr", imem_addr_po, 8'h00);
    chk("rst_clk_en", clk_en_po, 0);
    chk("rst_dmem_req", dmem_req_po, 0);
    chk("rst_halted", halted_po, 0);
    chk("rst_dest", destination_reg_po, 0);
    @(negedge clk_pi);
    reset_pi = 1'b0;
    @(negedge clk_pi);
    chk("fetch0_addr", imem_addr_po, 8'h00);

    // ADD rd=1 rs1=2 rs2=3
    fetch(16'h1298);
    chk("add_dec_clk_en", clk_en_po, 0);
    @(negedge clk_pi);
    chk("add_clk_en", clk_en_po, 1);
    chk("add_wr", wr_destination_reg_po, 1);
    chk("add_flag_hold", flag_hold_po, 0);
    chk("add_dest", destination_reg_po, 1);
    chk("add_rs1", source_reg1_po, 2);
    chk("add_rs2", source_reg2_po, 3);
    chk("add_op", alu_op_po, 4'h1);
    @(negedge clk_pi);
    chk("add_clk_en_after", clk_en_po, 0);
    chk("add_next_addr", imem_addr_po, 8'h01);

    // MOVIL rd=2 imm=AB; a stray imem ack while req is low must be ignored
    fetch(16'h94AB);
    imem_ack_pi  = 1'b1;
    imem_data_pi = 16'hF000;
    chk("movil_dec_req", imem_req_po, 0);
    @(negedge clk_pi);
    imem_ack_pi  = 1'b0;
    chk("movil_clk_en", clk_en_po, 1);
    chk("movil_lower", movi_lower_po, 1);
    chk("movil_higher", movi_higher_po, 0);
    chk("movil_imm", immediate_po, 8'hAB);
    chk("movil_flag_hold", flag_hold_po, 1);
    chk("movil_wr", wr_destination_reg_po, 1);
    chk("movil_dest", destination_reg_po, 2);
    @(negedge clk_pi);
    chk("movil_next_addr", imem_addr_po, 8'h02);
    chk("movil_not_halted", halted_po, 0);

    // LOAD rd=3 rs1=2, ack on the third MEM cycle
    reg1_data_pi = 16'h0040;
    fetch(16'hB680);
    @(negedge clk_pi);
    chk("ld_req1", dmem_req_po, 1);
    chk("ld_we", dmem_we_po, 0);
    chk("ld_addr", dmem_addr_po, 16'h0040);
    chk("ld_mem_clk_en", clk_en_po, 0);
    @(negedge clk_pi);
    chk("ld_req2", dmem_req_po, 1);
    @(negedge clk_pi);
    chk("ld_req3", dmem_req_po, 1);
    dmem_ack_pi   = 1'b1;
    dmem_rdata_pi = 16'hBEEF;
    @(negedge clk_pi);
    dmem_ack_pi   = 1'b0;
    chk("ld_wb_clk_en", clk_en_po, 1);
    chk("ld_wb_sel", load_sel_po, 1);
    chk("ld_wb_wr", wr_destination_reg_po, 1);
    chk("ld_wb_dest", destination_reg_po, 3);
    chk("ld_wb_data", load_data_po, 16'hBEEF);
    chk("ld_wb_flag_hold", flag_hold_po, 1);
    chk("ld_wb_dmem_req", dmem_req_po, 0);
    @(negedge clk_pi);
    chk("ld_next_addr", imem_addr_po, 8'h03);

    // STORE rd=1 rs1=1
    reg1_data_pi = 16'h0010;
    regD_data_pi = 16'h1234;
    fetch(16'hC240);
    @(negedge clk_pi);
    chk("st_req", dmem_req_po, 1);
    chk("st_we", dmem_we_po, 1);
    chk("st_addr", dmem_addr_po, 16'h0010);
    chk("st_wdata", dmem_wdata_po, 16'h1234);
    dmem_ack_pi = 1'b1;
    dmem_rdata_pi = 16'h5555;
    @(negedge clk_pi);
    dmem_ack_pi = 1'b0;
    chk("st_wb_clk_en", clk_en_po, 1);
    chk("st_wb_wr", wr_destination_reg_po, 0);
    chk("st_wb_sel", load_sel_po, 0);
    chk("st_wb_flag_hold", flag_hold_po, 1);
    chk("st_load_data_kept", load_data_po, 16'hBEEF);
    @(negedge clk_pi);
    chk("st_next_addr", imem_addr_po, 8'h04);

    // Reset in the middle of a LOAD's MEM phase; the late ack is ignored
    fetch(16'hB680);
    @(negedge clk_pi);
    chk("rst_mem_req_before", dmem_req_po, 1);
    #2 reset_pi = 1'b1;
    #1;
    chk("rstm_dmem_req", dmem_req_po, 0);
    chk("rstm_load_data", load_data_po, 16'h0000);
    chk("rstm_dest", destination_reg_po, 0);
    chk("rstm_alu_op", alu_op_po, 0);
    chk("rstm_imem_req", imem_req_po, 0);
    chk("rstm_imem_addr", imem_addr_po, 8'h00);
    dmem_ack_pi   = 1'b1;
    dmem_rdata_pi = 16'hDEAD;
    @(negedge clk_pi);
    reset_pi = 1'b0;
    @(negedge clk_pi);
    dmem_ack_pi = 1'b0;
    chk("rstm_after_req", imem_req_po, 1);
    chk("rstm_after_addr", imem_addr_po, 8'h00);
    chk("rstm_after_load_data", load_data_po, 16'h0000);
    chk("rstm_after_clk_en", clk_en_po, 0);

    // Reset while waiting in FETCH with no ack
    fetch(16'h0000);
    @(negedge clk_pi);
    chk("nop_flag_hold", flag_hold_po, 1);
    chk("nop_wr", wr_destination_reg_po, 0);
    @(negedge clk_pi);
    chk("rstf_pre_addr", imem_addr_po, 8'h01);
    #2 reset_pi = 1'b1;
    #1;
    chk("rstf_imem_req", imem_req_po, 0);
    chk("rstf_imem_addr", imem_addr_po, 8'h00);
    @(negedge clk_pi);
    reset_pi = 1'b0;
    @(negedge clk_pi);
    chk("rstf_after_addr", imem_addr_po, 8'h00);

    // Walk NOPs up to PC=0xFF, then HALT there so PC wraps to 0
    n = 0;
    while (imem_addr_po != 8'hFF && n < 300) begin
      fetch(16'h0000);
      @(negedge clk_pi);
      @(negedge clk_pi);
      n++;
    end
    chk("pc_reach_ff", imem_addr_po, 8'hFF);
    fetch(16'hF000);
    chk("halt_wrap_addr", imem_addr_po, 8'h00);
    imem_ack_pi = 1'b1;
    @(negedge clk_pi);
    for (int i = 0; i < 4; i++) begin
      chk("halt_halted", halted_po, 1);
      chk("halt_no_req", imem_req_po, 0);
      chk("halt_no_clk_en", clk_en_po, 0);
      chk("halt_addr_held", imem_addr_po, 8'h00);
      @(negedge clk_pi);
    end
    imem_ack_pi = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle fetch/decode/commit controller that sits directly upstream of the 8x16 register file.
- Fetches 16-bit instructions over a req/ack instruction-memory port and decodes them into register-file controls: source/destination indices, write enable, movi strobes, immediate, commit strobe.
- Sequences LOAD/STORE through a req/ack data-memory port.
- The register file updates CARRY/BORROW on every commit, so this block tells the flag path when to hold the current flags.

Parameters:
- PC_W, 8, program-counter / instruction-address width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk_pi  in  1  clock
- reset_pi  in  1  reset; asynchronous, active-high
- imem_req_po  out  1  instruction fetch request
- imem_addr_po  out  PC_W  fetch address (current PC)
- imem_ack_pi  in  1  instruction valid this cycle
- imem_data_pi  in  16  instruction word
- source_reg1_po  out  3  rs1 index to register file
- source_reg2_po  out  3  rs2 index to register file
- destination_reg_po  out  3  rd index (also STORE data source)
- wr_destination_reg_po  out  1  rd write enable
- movi_lower_po  out  1  MOVIL strobe
- movi_higher_po  out  1  MOVIH strobe
- immediate_po  out  8  immediate byte
- clk_en_po  out  1  one-cycle commit strobe to register file
- alu_op_po  out  4  opcode forwarded to ALU
- flag_hold_po  out  1  ALU-bypass flags: feed current CARRY/BORROW back unchanged
- load_sel_po  out  1  writeback mux selects load_data_po instead of ALU result
- load_data_po  out  16  latched load data
- reg1_data_pi  in  16  register-file rs1 value (memory address)
- regD_data_pi  in  16  register-file rd value (store data)
- dmem_req_po  out  1  data-memory request
- dmem_we_po  out  1  1 = store
- dmem_addr_po  out  16  = reg1_data_pi
- dmem_wdata_po  out  16  = regD_data_pi
- dmem_ack_pi  in  1  data access complete
- dmem_rdata_pi  in  16  load data
- halted_po  out  1  HALT executed

Behaviour:
- Reset (async, active-high), all outputs and state:
  - state = FETCH, PC = RESET_PC, IR = 0.
  - All *_po outputs are 0, except imem_addr_po = RESET_PC.
  - Registered outputs clear immediately on assertion.
  - Reset mid-operation abandons any outstanding request; a late ack is ignored.
- Instruction fields:
  - op = [15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm = [7:0].
- Opcodes:
  - 0 NOP, 1 ADD, 2 ADDC, 3 SUB, 4 SUBB, 5 AND, 6 OR, 7 XOR, 8 NOT
  - 9 MOVIL, A MOVIH, B LOAD, C STORE
  - D–E reserved (treated as NOP), F HALT
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req_po = 1, held until imem_ack_pi.
  - On ack: IR <= imem_data_pi; PC <= PC+1, wrapping mod 2^PC_W; go to DECODE.
- DECODE (1 cycle):
  - Register all index, op and immediate outputs from IR; they remain stable through commit.
  - F -> HALT; B/C -> MEM; all others -> EXEC.
- EXEC (1 cycle): clk_en_po = 1, then go to FETCH.
  - wr_destination_reg_po = 1 for ops 1–A.
  - movi_lower_po = 1 for 9; movi_higher_po = 1 for A.
  - flag_hold_po = 1 for ops 0, 5–A and D–E.
- MEM:
  - dmem_req_po = 1, dmem_we_po = (op == C); held until dmem_ack_pi.
  - On ack for LOAD: load_data_po <= dmem_rdata_pi.
  - On ack: go to WB.
- WB (1 cycle): clk_en_po = 1, flag_hold_po = 1, then go to FETCH.
  - LOAD: wr_destination_reg_po = 1, load_sel_po = 1.
  - STORE: no write.
- Strobe rules:
  - clk_en_po is high for exactly one cycle per non-HALT instruction; it is 0 in every other state.
  - wr/movi/load_sel strobes are asserted only in the same cycle as clk_en_po.
- HALT:
  - halted_po = 1, no requests issued.
  - Exits only via reset.
  - HALT never asserts clk_en_po.
- Latency with same-cycle acks:
  - ALU/movi ops: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD/STORE: 4 cycles (FETCH, DECODE, MEM, WB).
- An ack arriving while its req is low is ignored.

Decomposition:
- Shared package holds the opcode constants (OP_NOP..OP_HALT), the field bit positions, and the state encoding.
- One natural sub-module: instr_decode, a combinational mapping from op to {wr, movil, movih, flag_hold, is_mem, is_store, is_halt}.

Test Plan:
- Reset mid-FETCH with imem_ack_pi low -> outputs 0 immediately; after release the next fetch uses imem_addr_po = RESET_PC.
- Fetch 0x1298 (ADD rd=1, rs1=2, rs2=3), ack same cycle -> after DECODE, EXEC cycle shows clk_en_po = 1, wr = 1, flag_hold = 0, destination = 1, sources 2/3; next fetch addr = 1.
- Fetch 0x94AB (MOVIL rd=2, imm=0xAB) -> clk_en = 1, movi_lower = 1, immediate = 0xAB, flag_hold = 1.
- LOAD 0xB680, dmem_ack_pi delayed 3 cycles with rdata 0xBEEF -> dmem_req held 3 cycles, then WB: load_data = 0xBEEF, load_sel = 1, wr = 1, destination = 3.
- STORE 0xC240 with regD = 0x1234, reg1 = 0x0010 -> dmem_we = 1, addr = 0x0010, wdata = 0x1234; WB clk_en = 1, wr = 0.
- PC = 0xFF then fetch -> PC wraps to 0x00; fetch 0xF000 -> halted_po = 1, no further imem_req_po, clk_en_po stays 0.
